idex_pipe_reg: RTL and testbench
================================

Name: idex_pipe_reg

Overview:
- Parametrised ID/EX pipeline register with valid/ready handshake, optional 2-entry skid buffer, synchronous flush and stall-cycle counter.
- Sits between decode and execute and carries decoded control bits plus operand/constant/address payload.
- Supports back-pressure from EX without losing an in-flight instruction.
- Guarantees a bubble (all control bits zero) whenever the stage is empty or flushed, so no spurious RegWrite/MemWrite reaches EX.

Parameters:
- DATA_W, 96, payload width: RdDataS, RdDataT, constant, incremented PC, disp, RT/RD packed by the instantiator.
- CTRL_W, 12, control-bit width: RegDst, AluSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, AluCode; zeroed on bubble.
- SKID, 1, 1 selects the 2-entry skid buffer; 0 selects a single register with combinational ready.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  ID presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_ctrl  in  CTRL_W  decoded control bits.
- in_data  in  DATA_W  payload.
- flush  in  1  synchronous kill of all held and incoming entries (branch taken).
- out_valid  out  1  EX entry valid.
- out_ready  in  1  EX consumes this cycle.
- out_ctrl  out  CTRL_W  control to EX; zero whenever out_valid=0.
- out_data  out  DATA_W  payload to EX.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Reset (asynchronous, any time including mid-transfer): out_valid=0, out_ctrl=0, out_data=0, skid entry invalid, stall_cnt=0. in_ready reads 1 while in reset (SKID=1) or follows its equation (SKID=0). In-flight entries are lost.
- Accept: in_valid && in_ready at the edge. Deliver: out_valid && out_ready at the edge.
- Latency: an accepted entry appears on out_* on the next cycle when the main register is free.
- SKID=0:
  - in_ready = out_ready || !out_valid (combinational).
  - Main register loads on accept. out_valid clears on deliver without a same-cycle accept.
- SKID=1: main register M plus skid register S.
  - in_ready = !S.valid, driven from a register with no combinational path from out_ready.
  - Accept with M empty, or M delivering this cycle and S empty: load M.
  - Accept with M held (out_ready=0): load S. in_ready falls next cycle.
  - Deliver with S valid: M<=S and S empties. If an accept also occurs in that cycle, the accepted entry goes to S (it cannot, since in_ready=0 while S is valid). Order is always preserved.
  - Sustained throughput is 1 entry per cycle when out_ready=1.
- Hold: while out_valid && !out_ready, out_ctrl and out_data are stable.
- flush (highest priority, synchronous):
  - Next cycle: out_valid=0, S invalid, out_ctrl=0. out_data is don't-care and held.
  - Any same-cycle accept is discarded; in_ready still reads as computed, and the discarded entry counts as accepted upstream.
  - A same-cycle deliver completes normally.
- Bubble rule: out_ctrl = 0 whenever out_valid = 0; registered zeroing, not output gating.
- stall_cnt:
  - +1 each cycle with out_valid && !out_ready.
  - Saturates at 2^CNT_W−1.
  - Cleared only by rst; flush does not clear it.
- Simultaneous flush and rst: rst wins.

Test Plan:
- Reset mid-stream: stream 3 entries, assert rst between edges -> out_valid=0 and out_ctrl=0 immediately (asynchronous); after release, first accept of ctrl=0x0A5, data=0x1 appears 1 cycle later.
- Streaming, SKID=1, out_ready=1: 8 back-to-back entries data=0..7 -> delivered in order at 1/cycle, latency 1, in_ready constantly 1, stall_cnt=0.
- Back-pressure, SKID=1: out_ready=0 for 4 cycles while sending A, B, C -> A held on out, B in skid, in_ready=0 from 2nd cycle, C held upstream; release -> A, B, C delivered in order, stall_cnt=4.
- Flush with full skid: M=A, S=B, out_ready=0, flush=1 with in_valid=1 (C) -> next cycle out_valid=0, out_ctrl=0, in_ready=1; C is never delivered.
- SKID=0 instance: out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle; out_ready=1 with in_valid=1 -> replacement loaded with no bubble.
- Saturation, CNT_W=4: hold out_ready=0 for 20 cycles with out_valid=1 -> stall_cnt stops at 15.

Source files
------------

// File: rtl/idex_pipe_reg_if.sv
// ID/EX stage handshake bundle: upstream valid/ready/payload, downstream valid/ready/payload, flush.
// master drives the ID side and consumes EX outputs; slave is the pipeline register itself.
interface idex_pipe_reg_if #(
  parameter int unsigned CTRL_W = 12,
  parameter int unsigned DATA_W = 96
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_ctrl, in_data, flush, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );

  modport slave (
    input  in_valid, in_ctrl, in_data, flush, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );
endinterface

// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register: valid/ready handshake, optional 2-entry skid buffer,
// synchronous flush producing a zero-control bubble, saturating stall-cycle counter.
module idex_pipe_reg #(
  parameter int unsigned DATA_W = 96,
  parameter int unsigned CTRL_W = 12,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  idex_pipe_reg_if.slave   pif,
  output logic [CNT_W-1:0] stall_cnt
);

  logic              m_valid_q, m_valid_d;
  logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
  logic [DATA_W-1:0] m_data_q,  m_data_d;
  logic              s_valid_q, s_valid_d;
  logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
  logic [DATA_W-1:0] s_data_q,  s_data_d;
  logic [CNT_W-1:0]  stall_q,   stall_d;
  logic              in_ready;
  logic              accept;
  logic              deliver;

  // With the skid buffer, in_ready depends only on a flop so out_ready never reaches upstream.
  always_comb begin
    if (SKID != 0) in_ready = !s_valid_q;
    else           in_ready = pif.out_ready || !m_valid_q;
  end

  always_comb begin
    accept    = pif.in_valid && in_ready;
    deliver   = m_valid_q && pif.out_ready;
    m_valid_d = m_valid_q;
    m_ctrl_d  = m_ctrl_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_ctrl_d  = s_ctrl_q;
    s_data_d  = s_data_q;
    stall_d   = stall_q;

    if (m_valid_q && !pif.out_ready && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);

    if (pif.flush) begin
      m_valid_d = 1'b0;
      m_ctrl_d  = '0;
      s_valid_d = 1'b0;
      s_ctrl_d  = '0;
    end else if (SKID == 0) begin
      if (accept) begin
        m_valid_d = 1'b1;
        m_ctrl_d  = pif.in_ctrl;
        m_data_d  = pif.in_data;
      end else if (deliver) begin
        m_valid_d = 1'b0;
        m_ctrl_d  = '0;
      end
    end else if (deliver || !m_valid_q) begin
      // Main slot frees up: drain the skid entry first to keep order; accept is impossible then.
      if (s_valid_q) begin
        m_valid_d = 1'b1;
        m_ctrl_d  = s_ctrl_q;
        m_data_d  = s_data_q;
        s_valid_d = 1'b0;
        s_ctrl_d  = '0;
      end else if (accept) begin
        m_valid_d = 1'b1;
        m_ctrl_d  = pif.in_ctrl;
        m_data_d  = pif.in_data;
      end else begin
        m_valid_d = 1'b0;
        m_ctrl_d  = '0;
      end
    end else if (accept) begin
      s_valid_d = 1'b1;
      s_ctrl_d  = pif.in_ctrl;
      s_data_d  = pif.in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_ctrl_q  <= '0;
      m_data_q  <= '0;
      s_valid_q <= 1'b0;
      s_ctrl_q  <= '0;
      s_data_q  <= '0;
      stall_q   <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_ctrl_q  <= m_ctrl_d;
      m_data_q  <= m_data_d;
      s_valid_q <= s_valid_d;
      s_ctrl_q  <= s_ctrl_d;
      s_data_q  <= s_data_d;
      stall_q   <= stall_d;
    end
  end

  always_comb begin
    pif.in_ready  = in_ready;
    pif.out_valid = m_valid_q;
    pif.out_ctrl  = m_ctrl_q;
    pif.out_data  = m_data_q;
    stall_cnt     = stall_q;
  end

endmodule

// File: tb/tb_idex_pipe_reg.sv
// Self-checking bench for idex_pipe_reg: skid, no-skid and narrow-counter instances
// compared against FIFO-queue reference models.
module tb_idex_pipe_reg;
  localparam int unsigned CW = 12;
  localparam int unsigned DW = 96;
  typedef logic [CW+DW-1:0] ent_t;

  logic clk;
  logic rst;
  logic [15:0] m_stall;
  logic [15:0] z_stall;
  logic [3:0]  s_stall;

  idex_pipe_reg_if #(.CTRL_W(CW), .DATA_W(DW)) mif ();
  idex_pipe_reg_if #(.CTRL_W(CW), .DATA_W(DW)) zif ();
  idex_pipe_reg_if #(.CTRL_W(CW), .DATA_W(DW)) sif ();

  idex_pipe_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(16)) u_main (
    .clk(clk), .rst(rst), .pif(mif.slave), .stall_cnt(m_stall));
  idex_pipe_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) u_noskid (
    .clk(clk), .rst(rst), .pif(zif.slave), .stall_cnt(z_stall));
  idex_pipe_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .pif(sif.slave), .stall_cnt(s_stall));

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  ent_t mq[$];
  ent_t zq[$];
  int unsigned mstall, zstall;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1);
  end

  function automatic ent_t rand_ent();
    return ent_t'({$urandom, $urandom, $urandom, $urandom});
  endfunction

  function automatic ent_t mk_ent(input logic [CW-1:0] c, input logic [DW-1:0] d);
    return {c, d};
  endfunction

  task automatic drive_m(input logic v, input ent_t e, input logic r, input logic f);
    mif.in_valid  = v;
    mif.in_ctrl   = e[CW+DW-1:DW];
    mif.in_data   = e[DW-1:0];
    mif.out_ready = r;
    mif.flush     = f;
  endtask

  task automatic drive_z(input logic v, input ent_t e, input logic r, input logic f);
    zif.in_valid  = v;
    zif.in_ctrl   = e[CW+DW-1:DW];
    zif.in_data   = e[DW-1:0];
    zif.out_ready = r;
    zif.flush     = f;
  endtask

  task automatic drive_s(input logic v, input ent_t e, input logic r);
    sif.in_valid  = v;
    sif.in_ctrl   = e[CW+DW-1:DW];
    sif.in_data   = e[DW-1:0];
    sif.out_ready = r;
    sif.flush     = 1'b0;
  endtask

  // Advance one edge; models are FIFOs: skid stage holds up to 2, plain stage up to 1.
  task automatic tick();
    bit acc, dlv;
    @(posedge clk);
    acc = mif.in_valid && (mq.size() < 2);
    dlv = (mq.size() > 0) && mif.out_ready;
    if ((mq.size() > 0) && !mif.out_ready && mstall < 32'hFFFF) mstall++;
    if (dlv) void'(mq.pop_front());
    if (mif.flush) mq.delete();
    else if (acc) mq.push_back(mk_ent(mif.in_ctrl, mif.in_data));
    acc = zif.in_valid && ((zq.size() == 0) || zif.out_ready);
    dlv = (zq.size() > 0) && zif.out_ready;
    if ((zq.size() > 0) && !zif.out_ready && zstall < 32'hFFFF) zstall++;
    if (dlv) void'(zq.pop_front());
    if (zif.flush) zq.delete();
    else if (acc) zq.push_back(mk_ent(zif.in_ctrl, zif.in_data));
    #1;
  endtask

  task automatic apply_reset();
    drive_m(1'b0, '0, 1'b1, 1'b0);
    drive_z(1'b0, '0, 1'b1, 1'b0);
    drive_s(1'b0, '0, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    mq.delete(); zq.delete();
    mstall = 0; zstall = 0;
  endtask

  task automatic test_reset();
    ent_t e;
    apply_reset();
    n_checks++; if (mif.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid actual=%b required=0", mif.out_valid); end
    n_checks++; if (mif.out_ctrl !== '0) begin n_fail++; $display("FAIL reset_out_ctrl actual=%h required=0", mif.out_ctrl); end
    n_checks++; if (mif.out_data !== '0) begin n_fail++; $display("FAIL reset_out_data actual=%h required=0", mif.out_data); end
    n_checks++; if (mif.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready actual=%b required=1", mif.in_ready); end
    n_checks++; if (m_stall !== 16'd0) begin n_fail++; $display("FAIL reset_stall actual=%0d required=0", m_stall); end
    for (int unsigned i = 0; i < 3; i++) begin
      drive_m(1'b1, rand_ent(), 1'b1, 1'b0);
      tick();
    end
    drive_m(1'b0, '0, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (mif.out_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid actual=%b required=0", mif.out_valid); end
    n_checks++; if (mif.out_ctrl !== '0) begin n_fail++; $display("FAIL async_rst_ctrl actual=%h required=0", mif.out_ctrl); end
    n_checks++; if (mif.in_ready !== 1'b1) begin n_fail++; $display("FAIL in_rst_in_ready actual=%b required=1", mif.in_ready); end
    @(posedge clk);
    #2;
    rst = 1'b0;
    mq.delete(); zq.delete(); mstall = 0; zstall = 0;
    e = mk_ent(12'h0A5, 96'h1);
    drive_m(1'b1, e, 1'b1, 1'b0);
    #1;
    tick();
    drive_m(1'b0, '0, 1'b1, 1'b0);
    #1;
    n_checks++; if (mif.out_valid !== 1'b1) begin n_fail++; $display("FAIL post_rst_valid actual=%b required=1", mif.out_valid); end
    n_checks++; if (mif.out_ctrl !== 12'h0A5) begin n_fail++; $display("FAIL post_rst_ctrl actual=%h required=0a5", mif.out_ctrl); end
    n_checks++; if (mif.out_data !== 96'h1) begin n_fail++; $display("FAIL post_rst_data actual=%h required=1", mif.out_data); end
    tick();
  endtask

  task automatic test_streaming();
    apply_reset();
    for (int unsigned i = 0; i < 9; i++) begin
      if (i < 8) drive_m(1'b1, mk_ent(CW'($urandom), DW'(i)), 1'b1, 1'b0);
      else       drive_m(1'b0, '0, 1'b1, 1'b0);
      #1;
      n_checks++; if (mif.in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d] actual=%b required=1", i, mif.in_ready); end
      if (i > 0) begin
        n_checks++; if (mif.out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d] actual=%b required=1", i, mif.out_valid); end
        n_checks++; if (mif.out_data !== DW'(i - 1)) begin n_fail++; $display("FAIL stream_data[%0d] actual=%h required=%h", i, mif.out_data, DW'(i - 1)); end
        n_checks++; if (mif.out_ctrl !== mq[0][CW+DW-1:DW]) begin n_fail++; $display("FAIL stream_ctrl[%0d] actual=%h required=%h", i, mif.out_ctrl, mq[0][CW+DW-1:DW]); end
      end
      tick();
    end
    n_checks++; if (mif.out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drained actual=%b required=0", mif.out_valid); end
    n_checks++; if (m_stall !== 16'd0) begin n_fail++; $display("FAIL stream_stall actual=%0d required=0", m_stall); end
  endtask

  task automatic test_back_pressure();
    ent_t a, b, c, cur;
    ent_t got[$];
    bit c_sent;
    apply_reset();
    a = rand_ent(); b = rand_ent(); c = rand_ent();
    for (int unsigned k = 0; k < 5; k++) begin
      cur = (k == 0) ? a : ((k == 1) ? b : c);
      drive_m(1'b1, cur, 1'b0, 1'b0);
      #1;
      n_checks++; if (mif.in_ready !== (k < 2)) begin n_fail++; $display("FAIL bp_in_ready[%0d] actual=%b required=%b", k, mif.in_ready, (k < 2)); end
      if (k > 0) begin
        n_checks++; if (mif.out_data !== a[DW-1:0]) begin n_fail++; $display("FAIL bp_hold_data[%0d] actual=%h required=%h", k, mif.out_data, a[DW-1:0]); end
      end
      tick();
    end
    c_sent = 1'b0;
    for (int unsigned k = 0; k < 8; k++) begin
      drive_m(!c_sent, c, 1'b1, 1'b0);
      if (!c_sent && mq.size() < 2) c_sent = 1'b1;
      #1;
      if (mif.out_valid === 1'b1) got.push_back(mk_ent(mif.out_ctrl, mif.out_data));
      tick();
    end
    n_checks++; if (got.size() != 3) begin n_fail++; $display("FAIL bp_count actual=%0d required=3", got.size()); end
    n_checks++; if (got.size() < 1 || got[0] !== a) begin n_fail++; $display("FAIL bp_order_a actual=%h required=%h", (got.size() > 0) ? got[0] : '0, a); end
    n_checks++; if (got.size() < 2 || got[1] !== b) begin n_fail++; $display("FAIL bp_order_b actual=%h required=%h", (got.size() > 1) ? got[1] : '0, b); end
    n_checks++; if (got.size() < 3 || got[2] !== c) begin n_fail++; $display("FAIL bp_order_c actual=%h required=%h", (got.size() > 2) ? got[2] : '0, c); end
    n_checks++; if (m_stall !== 16'd4) begin n_fail++; $display("FAIL bp_stall actual=%0d required=4", m_stall); end
  endtask

  task automatic test_flush();
    apply_reset();
    drive_m(1'b1, rand_ent(), 1'b0, 1'b0); tick();
    drive_m(1'b1, rand_ent(), 1'b0, 1'b0); tick();
    drive_m(1'b1, rand_ent(), 1'b0, 1'b1); tick();
    drive_m(1'b0, '0, 1'b0, 1'b0);
    #1;
    n_checks++; if (mif.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid actual=%b required=0", mif.out_valid); end
    n_checks++; if (mif.out_ctrl !== '0) begin n_fail++; $display("FAIL flush_ctrl actual=%h required=0", mif.out_ctrl); end
    n_checks++; if (mif.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready actual=%b required=1", mif.in_ready); end
    for (int unsigned k = 0; k < 4; k++) begin
      drive_m(1'b0, '0, 1'b1, 1'b0);
      tick();
      n_checks++; if (mif.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_c[%0d] actual=%b required=0", k, mif.out_valid); end
    end
  endtask

  task automatic test_random_main();
    ent_t h;
    apply_reset();
    for (int unsigned k = 0; k < 400; k++) begin
      drive_m($urandom_range(0, 9) < 7, rand_ent(), $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
      #1;
      h = (mq.size() > 0) ? mq[0] : '0;
      n_checks++; if (mif.in_ready !== (mq.size() < 2)) begin n_fail++; $display("FAIL rnd_in_ready[%0d] actual=%b required=%b", k, mif.in_ready, (mq.size() < 2)); end
      n_checks++; if (mif.out_valid !== (mq.size() > 0)) begin n_fail++; $display("FAIL rnd_valid[%0d] actual=%b required=%b", k, mif.out_valid, (mq.size() > 0)); end
      n_checks++; if (mif.out_ctrl !== h[CW+DW-1:DW]) begin n_fail++; $display("FAIL rnd_ctrl[%0d] actual=%h required=%h", k, mif.out_ctrl, h[CW+DW-1:DW]); end
      if (mq.size() > 0) begin
        n_checks++; if (mif.out_data !== h[DW-1:0]) begin n_fail++; $display("FAIL rnd_data[%0d] actual=%h required=%h", k, mif.out_data, h[DW-1:0]); end
      end
      n_checks++; if (m_stall !== 16'(mstall)) begin n_fail++; $display("FAIL rnd_stall[%0d] actual=%0d required=%0d", k, m_stall, mstall); end
      tick();
    end
  endtask

  task automatic test_no_skid();
    ent_t x, y, h;
    apply_reset();
    x = rand_ent(); y = rand_ent();
    drive_z(1'b1, x, 1'b0, 1'b0);
    #1;
    n_checks++; if (zif.in_ready !== 1'b1) begin n_fail++; $display("FAIL ns_empty_ready actual=%b required=1", zif.in_ready); end
    tick();
    drive_z(1'b1, y, 1'b0, 1'b0);
    #1;
    n_checks++; if (zif.in_ready !== 1'b0) begin n_fail++; $display("FAIL ns_held_ready actual=%b required=0", zif.in_ready); end
    n_checks++; if (zif.out_data !== x[DW-1:0]) begin n_fail++; $display("FAIL ns_held_data actual=%h required=%h", zif.out_data, x[DW-1:0]); end
    tick();
    drive_z(1'b1, y, 1'b1, 1'b0);
    #1;
    n_checks++; if (zif.in_ready !== 1'b1) begin n_fail++; $display("FAIL ns_comb_ready actual=%b required=1", zif.in_ready); end
    tick();
    drive_z(1'b0, '0, 1'b0, 1'b0);
    #1;
    n_checks++; if (zif.out_valid !== 1'b1) begin n_fail++; $display("FAIL ns_no_bubble actual=%b required=1", zif.out_valid); end
    n_checks++; if (zif.out_data !== y[DW-1:0]) begin n_fail++; $display("FAIL ns_replace_data actual=%h required=%h", zif.out_data, y[DW-1:0]); end
    for (int unsigned k = 0; k < 200; k++) begin
      drive_z($urandom_range(0, 9) < 7, rand_ent(), $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
      #1;
      h = (zq.size() > 0) ? zq[0] : '0;
      n_checks++; if (zif.in_ready !== ((zq.size() == 0) || zif.out_ready)) begin n_fail++; $display("FAIL ns_rnd_ready[%0d] actual=%b", k, zif.in_ready); end
      n_checks++; if (zif.out_valid !== (zq.size() > 0)) begin n_fail++; $display("FAIL ns_rnd_valid[%0d] actual=%b required=%b", k, zif.out_valid, (zq.size() > 0)); end
      n_checks++; if (zif.out_ctrl !== h[CW+DW-1:DW]) begin n_fail++; $display("FAIL ns_rnd_ctrl[%0d] actual=%h required=%h", k, zif.out_ctrl, h[CW+DW-1:DW]); end
      if (zq.size() > 0) begin
        n_checks++; if (zif.out_data !== h[DW-1:0]) begin n_fail++; $display("FAIL ns_rnd_data[%0d] actual=%h required=%h", k, zif.out_data, h[DW-1:0]); end
      end
      n_checks++; if (z_stall !== 16'(zstall)) begin n_fail++; $display("FAIL ns_rnd_stall[%0d] actual=%0d required=%0d", k, z_stall, zstall); end
      tick();
    end
  endtask

  task automatic test_saturation();
    int unsigned exp;
    apply_reset();
    drive_s(1'b1, rand_ent(), 1'b0);
    tick();
    drive_s(1'b0, '0, 1'b0);
    #1;
    n_checks++; if (s_stall !== 4'd0) begin n_fail++; $display("FAIL sat_start actual=%0d required=0", s_stall); end
    for (int unsigned k = 1; k <= 20; k++) begin
      tick();
      exp = (k > 15) ? 15 : k;
      n_checks++; if (s_stall !== 4'(exp)) begin n_fail++; $display("FAIL sat_cnt[%0d] actual=%0d required=%0d", k, s_stall, exp); end
    end
    n_checks++; if (sif.out_valid !== 1'b1) begin n_fail++; $display("FAIL sat_valid actual=%b required=1", sif.out_valid); end
  endtask

  initial begin
    rst = 1'b1;
    drive_m(1'b0, '0, 1'b1, 1'b0);
    drive_z(1'b0, '0, 1'b1, 1'b0);
    drive_s(1'b0, '0, 1'b1);
    #12;
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_random_main();
    test_no_skid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
